regfile_bist_ctrl: RTL and testbench

//  Built-in self-test initiator for the 32x32 register file: drives the write port (Awr/Din/WrEn)
//  and both async read ports (Adr1/Adr2), then checks Dout1/Dout2 against a seeded pattern.

---
 rtl/regfile_bist_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_bist_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist_ctrl.sv
// BIST initiator for the 32x32 register file: writes a seeded pattern, reads it back in pairs.
// Optional complement second pass is enabled by defining REGFILE_BIST_INV_PASS_EN.
module regfile_bist_ctrl #(
    parameter int NREGS   = 32,
    parameter int SKIP_R0 = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [31:0] Seed,
    output logic        Busy,
    output logic        Done,
    output logic        Fail,
    output logic [4:0]  FailAdr,
    output logic [4:0]  Adr1,
    output logic [4:0]  Adr2,
    output logic [4:0]  Awr,
    output logic [31:0] Din,
    output logic        WrEn,
    input  logic [31:0] Dout1,
    input  logic [31:0] Dout2
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [5:0] K0    = (SKIP_R0 != 0) ? 6'd1 : 6'd0;
    localparam logic [5:0] KLAST = 6'(NREGS - 1);

`ifdef REGFILE_BIST_INV_PASS_EN
    localparam bit INV_PASS = 1'b1;
`else
    localparam bit INV_PASS = 1'b0;
`endif

    state_t      state;
    logic [5:0]  k;
    logic [5:0]  k_p1;
    logic [5:0]  k_p2;
    logic [31:0] seed_l;
    logic        inv;
    logic        vld_p1;
    logic        rd_last;
    logic        err1;
    logic        err2;

    function automatic logic [31:0] pat(input logic [4:0] a, input logic [31:0] s, input logic n);
        logic [31:0] p;
        p = s ^ {a, a, a, a, a, a, a[1:0]};
        return n ? ~p : p;
    endfunction

    // Second read address clamps at the top register instead of wrapping to 0.
    function automatic logic [4:0] sat_adr(input logic [5:0] a);
        return (a > KLAST) ? KLAST[4:0] : a[4:0];
    endfunction

    assign k_p1 = k + 6'd1;
    assign k_p2 = k + 6'd2;
    assign err1 = (Dout1 != pat(Adr1, seed_l, inv));
    assign err2 = (Dout2 != pat(Adr2, seed_l, inv));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Fail    <= 1'b0;
            FailAdr <= '0;
            Adr1    <= '0;
            Adr2    <= '0;
            Awr     <= '0;
            Din     <= '0;
            WrEn    <= 1'b0;
            k       <= '0;
            inv     <= 1'b0;
            vld_p1  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        seed_l  <= Seed;
                        Done    <= 1'b0;
                        Fail    <= 1'b0;
                        FailAdr <= '0;
                        Busy    <= 1'b1;
                        k       <= K0;
                        inv     <= 1'b0;
                        vld_p1  <= 1'b0;
                        rd_last <= 1'b0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    WrEn <= 1'b1;
                    Awr  <= k[4:0];
                    Din  <= pat(k[4:0], seed_l, inv);
                    if (k == KLAST) begin
                        k     <= K0;
                        state <= READ;
                    end else begin
                        k <= k_p1;
                    end
                end
                READ: begin
                    WrEn <= 1'b0;
                    Awr  <= '0;
                    Din  <= '0;
                    if (vld_p1 && (err1 || err2)) begin
                        Fail    <= 1'b1;
                        FailAdr <= err1 ? Adr1 : Adr2;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Adr1    <= '0;
                        Adr2    <= '0;
                        vld_p1  <= 1'b0;
                        state   <= DONE;
                    end else if (rd_last) begin
                        Adr1    <= '0;
                        Adr2    <= '0;
                        vld_p1  <= 1'b0;
                        rd_last <= 1'b0;
                        if (INV_PASS && !inv) begin
                            // First complement write is issued here so the second pass adds no gap cycle.
                            inv   <= 1'b1;
                            WrEn  <= 1'b1;
                            Awr   <= K0[4:0];
                            Din   <= pat(K0[4:0], seed_l, 1'b1);
                            k     <= (K0 == KLAST) ? K0 : K0 + 6'd1;
                            state <= (K0 == KLAST) ? READ : WRITE;
                        end else begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        Adr1    <= k[4:0];
                        Adr2    <= sat_adr(k_p1);
                        vld_p1  <= 1'b1;
                        rd_last <= (k_p2 > KLAST);
                        k       <= k_p2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Scoreboard bench for regfile_bist_ctrl with a behavioural 32x32 register file and fault injection.
// Build with REGFILE_BIST_INV_PASS_EN defined to exercise the complement pass.
module tb_regfile_bist_ctrl;
    localparam int W = 32;
`ifdef REGFILE_BIST_INV_PASS_EN
    localparam int LAT_PASS = 97;
`else
    localparam int LAT_PASS = 49;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [31:0] Seed;
    logic        Busy, Done, Fail, WrEn;
    logic [4:0]  FailAdr, Adr1, Adr2, Awr;
    logic [31:0] Din, Dout1, Dout2;

    regfile_bist_ctrl #(.NREGS(32), .SKIP_R0(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Seed(Seed),
        .Busy(Busy), .Done(Done), .Fail(Fail), .FailAdr(FailAdr),
        .Adr1(Adr1), .Adr2(Adr2), .Awr(Awr), .Din(Din), .WrEn(WrEn),
        .Dout1(Dout1), .Dout2(Dout2)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [32];
    logic        stuck4 = 1'b0;

    always @(posedge Clk) if (WrEn) mem[Awr] <= Din;

    always_comb begin
        Dout1 = mem[Adr1];
        Dout2 = mem[Adr2];
        if (stuck4 && Adr1 == 5'd4) Dout1[3] = 1'b1;
        if (stuck4 && Adr2 == 5'd4) Dout2[3] = 1'b1;
    end

    int unsigned ecnt = 0;
    always @(posedge Clk) ecnt <= ecnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    function automatic logic [31:0] pat(input logic [4:0] a, input logic [31:0] s);
        return s ^ {a, a, a, a, a, a, a[1:0]};
    endfunction

    typedef struct {
        int unsigned done_edge;
        logic        fail;
        logic [4:0]  fadr;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] cur_seed = '0;

    // Monitor: write stream and read pairs against the pattern model, Done against the scoreboard.
    logic busy_q = 1'b0, done_q = 1'b0;
    int   wr_cnt = 0;
    int   sat_seen = 0;
    always @(negedge Clk) begin
        exp_t        e;
        logic [4:0]  ea;
        logic [31:0] ed;
        if (Busy && !busy_q) wr_cnt = 0;
        if (Rst_n && WrEn) begin
            ea = 5'(wr_cnt % W);
            ed = pat(ea, cur_seed);
            if (wr_cnt >= W) ed = ~ed;
            chk("wr_awr", 64'(Awr), 64'(ea));
            chk("wr_din", 64'(Din), 64'(ed));
            if (cur_seed == 32'h00002232 && Awr == 5'd5)
                chk("din_p5", 64'(Din), (wr_cnt >= W) ? 64'hd6b58f58 : 64'h294a70a7);
            wr_cnt++;
        end
        if (Rst_n && Busy && !WrEn && Adr1 != 5'd0) begin
            chk("adr2_pair", 64'(Adr2), (Adr1 == 5'd31) ? 64'd31 : 64'(Adr1 + 5'd1));
            if (Adr1 == 5'd30) begin
                chk("adr2_sat", 64'(Adr2), 64'd31);
                sat_seen++;
            end
        end
        if (Done && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(Done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_edge", 64'(ecnt), 64'(e.done_edge));
                chk("fail", 64'(Fail), 64'(e.fail));
                chk("failadr", 64'(FailAdr), 64'(e.fadr));
                chk("busy_at_done", 64'(Busy), 64'd0);
                chk("ports_at_done", {27'd0, WrEn, Awr, Adr1, Adr2, Din}, 64'd0);
            end
        end
        busy_q = Busy;
        done_q = Done;
    end

    task automatic start_run(input logic [31:0] s, input bit push, input logic f,
                             input logic [4:0] fa, input int lat);
        exp_t e;
        Seed     = s;
        cur_seed = s;
        Start    = 1'b1;
        if (push) begin
            e.done_edge = ecnt + 1 + lat;
            e.fail      = f;
            e.fadr      = fa;
            exp_q.push_back(e);
        end
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        Rst_n = 1'b0;
        Start = 1'b1;
        Seed  = 32'hdeadbeef;
        // Reset wins over a held Start.
        repeat (2) @(negedge Clk);
        chk("reset_outs", {8'd0, Busy, Done, Fail, FailAdr, Adr1, Adr2, Awr, Din, WrEn}, 64'd0);
        Rst_n = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("idle_after_reset", {8'd0, Busy, Done, Fail, FailAdr, Adr1, Adr2, Awr, Din, WrEn}, 64'd0);

        // Fault-free run, then stuck-at-1 on bit 3 of reg 4 (read as Adr1 in the pair 4,5).
        start_run(32'h00002232, 1'b1, 1'b0, 5'd0, LAT_PASS);
        wait_q(200);
        stuck4 = 1'b1;
        start_run(32'h00002232, 1'b1, 1'b1, 5'd4, 36);
        wait_q(200);
        stuck4 = 1'b0;

        // Extra Start mid-run is ignored.
        start_run(32'h0f0f1234, 1'b1, 1'b0, 5'd0, LAT_PASS);
        repeat (8) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_q(200);

        // Reset during WRITE aborts the run; a fresh Start then runs to completion.
        start_run(32'hffffffff, 1'b0, 1'b0, 5'd0, 0);
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("abort_wren", 64'(WrEn), 64'd0);
        chk("abort_outs", {8'd0, Busy, Done, Fail, FailAdr, Adr1, Adr2, Awr, Din, WrEn}, 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("abort_idle", 64'(Busy), 64'd0);
        start_run(32'ha5a5c3c3, 1'b1, 1'b0, 5'd0, LAT_PASS);
        wait_q(200);

        chk("sat_seen", 64'(sat_seen > 0), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=finished", ecnt);
        $fatal(1, "timeout");
    end
endmodule
